// File: rtl/ecdsa_vector_sequencer.sv
// Control scheduler that walks a range of ECDSA test vectors, issues each to the
// shared verify engine, checks the verdict and accumulates run statistics.
module ecdsa_vector_sequencer #(
    parameter int IDX_W   = 10,
    parameter int CNT_W   = 11,
    parameter int TIMEOUT = 1048576
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] first_idx,
    input  logic [IDX_W-1:0] last_idx,
    output logic             vec_rd,
    output logic [IDX_W-1:0] vec_idx,
    input  logic             vec_rvalid,
    input  logic [1:0]       vec_expect,
    input  logic [1:0]       vec_curve,
    output logic             eng_req_valid,
    input  logic             eng_req_ready,
    output logic [1:0]       eng_curve,
    output logic             eng_abort,
    input  logic             eng_done,
    input  logic             eng_ok,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [CNT_W-1:0] tmo_cnt,
    output logic             fail_seen,
    output logic [IDX_W-1:0] first_fail_idx
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [1:0]         expect_q, expect_d;
    logic [1:0]         curve_q, curve_d;
    logic               ok_q, ok_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]   fail_q, fail_d;
    logic [CNT_W-1:0]   skip_q, skip_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic               fail_seen_q, fail_seen_d;
    logic [IDX_W-1:0]   first_fail_q, first_fail_d;
    logic               vec_rd_q, vec_rd_d;
    logic               mark_fail;
    logic               advance;
    logic               busy_w;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign busy_w = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                    (state_q == S_WAIT)  || (state_q == S_CHECK);

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        last_d       = last_q;
        expect_d     = expect_q;
        curve_d      = curve_q;
        ok_d         = ok_q;
        timer_d      = timer_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        skip_d       = skip_q;
        tmo_d        = tmo_q;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;
        vec_rd_d     = 1'b0;
        eng_abort    = 1'b0;
        mark_fail    = 1'b0;
        advance      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pass_d       = '0;
                    fail_d       = '0;
                    skip_d       = '0;
                    tmo_d        = '0;
                    fail_seen_d  = 1'b0;
                    first_fail_d = '0;
                    cur_d        = first_idx;
                    last_d       = last_idx;
                    state_d      = (first_idx > last_idx) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (vec_rvalid) begin
                    expect_d = vec_expect;
                    curve_d  = vec_curve;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (eng_req_ready) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A verdict arriving on the expiry cycle takes priority over the timeout.
                if (eng_done) begin
                    ok_d    = eng_ok;
                    state_d = S_CHECK;
                end else if (timer_q == TMR_LAST) begin
                    eng_abort = 1'b1;
                    tmo_d     = sat_inc(tmo_q);
                    fail_d    = sat_inc(fail_q);
                    mark_fail = 1'b1;
                    advance   = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_CHECK: begin
                advance = 1'b1;
                if (expect_q == 2'd2) begin
                    skip_d = sat_inc(skip_q);
                end else if ((expect_q == 2'd1 && ok_q) || (expect_q == 2'd0 && !ok_q)) begin
                    pass_d = sat_inc(pass_q);
                end else begin
                    fail_d    = sat_inc(fail_q);
                    mark_fail = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (mark_fail && !fail_seen_q) begin
            fail_seen_d  = 1'b1;
            first_fail_d = cur_q;
        end

        // Compare before incrementing so an all-ones last index never wraps.
        if (advance) begin
            if (cur_q == last_q) begin
                state_d = S_DONE;
            end else begin
                cur_d   = cur_q + IDX_W'(1);
                state_d = S_FETCH;
            end
        end

        if (busy_w && abort) begin
            eng_abort   = 1'b1;
            state_d     = S_IDLE;
            pass_d      = pass_q;
            fail_d      = fail_q;
            skip_d      = skip_q;
            tmo_d       = tmo_q;
            fail_seen_d = fail_seen_q;
            first_fail_d = first_fail_q;
            cur_d       = cur_q;
        end

        vec_rd_d = (state_d == S_FETCH) && (state_q != S_FETCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            last_q       <= '0;
            expect_q     <= '0;
            curve_q      <= '0;
            ok_q         <= 1'b0;
            timer_q      <= '0;
            pass_q       <= '0;
            fail_q       <= '0;
            skip_q       <= '0;
            tmo_q        <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
            vec_rd_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            last_q       <= last_d;
            expect_q     <= expect_d;
            curve_q      <= curve_d;
            ok_q         <= ok_d;
            timer_q      <= timer_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            skip_q       <= skip_d;
            tmo_q        <= tmo_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
            vec_rd_q     <= vec_rd_d;
        end
    end

    assign vec_rd         = vec_rd_q;
    assign vec_idx        = cur_q;
    assign eng_req_valid  = (state_q == S_ISSUE);
    assign eng_curve      = curve_q;
    assign busy           = busy_w;
    assign done           = (state_q == S_DONE);
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign skip_cnt       = skip_q;
    assign tmo_cnt        = tmo_q;
    assign fail_seen      = fail_seen_q;
    assign first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_ecdsa_vector_sequencer.sv
// Directed bench for ecdsa_vector_sequencer with a behavioural vector ROM and
// verify engine driven on the falling edge.
module tb_ecdsa_vector_sequencer;

    localparam int IDX_W = 10;
    localparam int CNT_W = 11;
    localparam int TMO   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, abort;
    logic [IDX_W-1:0] first_idx, last_idx;
    logic             vec_rd;
    logic [IDX_W-1:0] vec_idx;
    logic             vec_rvalid;
    logic [1:0]       vec_expect, vec_curve;
    logic             eng_req_valid, eng_req_ready;
    logic [1:0]       eng_curve;
    logic             eng_abort, eng_done, eng_ok;
    logic             busy, done;
    logic [CNT_W-1:0] pass_cnt, fail_cnt, skip_cnt, tmo_cnt;
    logic             fail_seen;
    logic [IDX_W-1:0] first_fail_idx;

    ecdsa_vector_sequencer #(.IDX_W(IDX_W), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_idx(first_idx), .last_idx(last_idx),
        .vec_rd(vec_rd), .vec_idx(vec_idx), .vec_rvalid(vec_rvalid),
        .vec_expect(vec_expect), .vec_curve(vec_curve),
        .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready),
        .eng_curve(eng_curve), .eng_abort(eng_abort),
        .eng_done(eng_done), .eng_ok(eng_ok),
        .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt), .tmo_cnt(tmo_cnt),
        .fail_seen(fail_seen), .first_fail_idx(first_fail_idx)
    );

    always #5 clk = ~clk;

    // Per-vector ROM contents and engine behaviour; latency 0 means the engine stays silent.
    logic [1:0] expTbl   [1024];
    logic [1:0] curveTbl [1024];
    logic       okTbl    [1024];
    int         latTbl   [1024];

    int romLat = 2;
    int romCnt = 0;
    int romIdx = 0;
    int engCnt = 0;
    int engIdx = 0;
    int readyHoldCfg = 0;
    int readyCnt = 0;

    int testsRun  = 0;
    int failCount = 0;

    int vecRdCount = 0;
    int xferCount = 0;
    int abortPulses = 0;
    int validCycles = 0;
    int stabErr = 0;
    int waitCyc = 0;
    int abortAt = -1;
    bit waitArmed = 1'b0;
    logic prevValid = 1'b0;
    logic prevReady = 1'b0;
    logic [1:0] prevCurve = 2'd0;

    // ROM and engine responders: outputs change only on the falling edge.
    always @(negedge clk) begin
        vec_rvalid = 1'b0;
        if (romCnt > 0) begin
            romCnt = romCnt - 1;
            if (romCnt == 0) begin
                vec_rvalid = 1'b1;
                vec_expect = expTbl[romIdx];
                vec_curve  = curveTbl[romIdx];
            end
        end
        if (vec_rd) begin
            romCnt = romLat;
            romIdx = int'(vec_idx);
        end

        eng_done = 1'b0;
        if (engCnt > 0) begin
            engCnt = engCnt - 1;
            if (engCnt == 0) begin
                eng_done = 1'b1;
                eng_ok   = okTbl[engIdx];
            end
        end
        if (eng_req_valid) begin
            if (readyCnt > 0) begin
                eng_req_ready = 1'b0;
                readyCnt = readyCnt - 1;
            end else begin
                eng_req_ready = 1'b1;
                engIdx = int'(vec_idx);
                engCnt = latTbl[engIdx];
            end
        end else begin
            eng_req_ready = 1'b0;
            readyCnt = readyHoldCfg;
        end
    end

    // Event monitor: samples the cycle that is ending at each rising edge.
    always @(posedge clk) begin
        if (vec_rd) vecRdCount++;
        if (eng_abort) abortPulses++;
        if (eng_req_valid) validCycles++;
        if (prevValid && !prevReady && (!eng_req_valid || eng_curve != prevCurve)) stabErr++;
        prevValid = eng_req_valid;
        prevReady = eng_req_ready;
        prevCurve = eng_curve;
        if (eng_req_valid && eng_req_ready) begin
            xferCount++;
            waitCyc = 0;
            waitArmed = 1'b1;
        end else if (waitArmed) begin
            waitCyc++;
        end
        if (eng_abort && waitArmed) abortAt = waitCyc;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int f, input int l);
        @(negedge clk);
        first_idx = IDX_W'(f);
        last_idx  = IDX_W'(l);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done"}, 32'(done), 1);
    endtask

    task automatic waitXfer(input int target, input int budget, input string tag);
        int n = 0;
        while (xferCount < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_xfer_reached"}, 32'(xferCount >= target), 1);
    endtask

    int rd0, xf0, ab0, vc0;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        first_idx = '0; last_idx = '0;
        vec_rvalid = 1'b0; vec_expect = '0; vec_curve = '0;
        eng_req_ready = 1'b0; eng_done = 1'b0; eng_ok = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            expTbl[i]   = 2'd1;
            okTbl[i]    = 1'b1;
            curveTbl[i] = 2'(i % 3);
            latTbl[i]   = 3;
        end

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_vec_rd", 32'(vec_rd), 0);
        checkOutput("rst_vec_idx", 32'(vec_idx), 0);
        checkOutput("rst_req_valid", 32'(eng_req_valid), 0);
        checkOutput("rst_eng_abort", 32'(eng_abort), 0);
        checkOutput("rst_counts", 32'(pass_cnt | fail_cnt | skip_cnt | tmo_cnt), 0);
        checkOutput("rst_fail_seen", 32'(fail_seen), 0);
        rst = 1'b0;
        @(negedge clk);

        // Range 0..3, mixed expectations and verdicts
        expTbl[0] = 2'd1; okTbl[0] = 1'b1;
        expTbl[1] = 2'd0; okTbl[1] = 1'b0;
        expTbl[2] = 2'd2; okTbl[2] = 1'b0;
        expTbl[3] = 2'd1; okTbl[3] = 1'b0;
        rd0 = vecRdCount; xf0 = xferCount;
        applyStimulus(0, 3);
        waitDone(300, "t1");
        checkOutput("t1_pass", 32'(pass_cnt), 2);
        checkOutput("t1_fail", 32'(fail_cnt), 1);
        checkOutput("t1_skip", 32'(skip_cnt), 1);
        checkOutput("t1_tmo", 32'(tmo_cnt), 0);
        checkOutput("t1_ffi", 32'(first_fail_idx), 3);
        checkOutput("t1_fail_seen", 32'(fail_seen), 1);
        checkOutput("t1_vec_rd", 32'(vecRdCount - rd0), 4);
        checkOutput("t1_xfer", 32'(xferCount - xf0), 4);
        checkOutput("t1_busy", 32'(busy), 0);

        // Empty range: first > last
        rd0 = vecRdCount; xf0 = xferCount; vc0 = validCycles;
        applyStimulus(5, 4);
        checkOutput("t2_done", 32'(done), 1);
        checkOutput("t2_counts", 32'(pass_cnt | fail_cnt | skip_cnt | tmo_cnt), 0);
        checkOutput("t2_fail_seen", 32'(fail_seen), 0);
        checkOutput("t2_ffi", 32'(first_fail_idx), 0);
        repeat (3) @(negedge clk);
        checkOutput("t2_vec_rd", 32'(vecRdCount - rd0), 0);
        checkOutput("t2_valid", 32'(validCycles - vc0), 0);

        // Engine backpressure for 10 cycles
        readyHoldCfg = 10;
        curveTbl[12] = 2'd2;
        xf0 = xferCount; vc0 = validCycles;
        applyStimulus(12, 12);
        waitDone(300, "t3");
        readyHoldCfg = 0;
        checkOutput("t3_xfer", 32'(xferCount - xf0), 1);
        checkOutput("t3_valid_cycles", 32'(validCycles - vc0), 11);
        checkOutput("t3_stability", 32'(stabErr), 0);
        checkOutput("t3_curve", 32'(eng_curve), 2);
        checkOutput("t3_pass", 32'(pass_cnt), 1);

        // Silent engine on vector 7 of 6..8
        latTbl[7] = 0;
        rd0 = vecRdCount; xf0 = xferCount; ab0 = abortPulses; abortAt = -1;
        applyStimulus(6, 8);
        waitDone(300, "t4");
        checkOutput("t4_tmo", 32'(tmo_cnt), 1);
        checkOutput("t4_fail", 32'(fail_cnt), 1);
        checkOutput("t4_pass", 32'(pass_cnt), 2);
        checkOutput("t4_ffi", 32'(first_fail_idx), 7);
        checkOutput("t4_abort_cycle", 32'(abortAt), 16);
        checkOutput("t4_abort_pulses", 32'(abortPulses - ab0), 1);
        checkOutput("t4_vec_rd", 32'(vecRdCount - rd0), 3);
        checkOutput("t4_last_idx", 32'(vec_idx), 8);

        // Verdict lands on the expiry cycle
        latTbl[7] = 16;
        ab0 = abortPulses;
        applyStimulus(6, 8);
        waitDone(300, "t4b");
        checkOutput("t4b_tmo", 32'(tmo_cnt), 0);
        checkOutput("t4b_fail", 32'(fail_cnt), 0);
        checkOutput("t4b_pass", 32'(pass_cnt), 3);
        checkOutput("t4b_abort_pulses", 32'(abortPulses - ab0), 0);
        latTbl[7] = 3;

        // Abort during WAIT of vector 2 of 0..9
        for (int i = 0; i < 10; i++) begin
            expTbl[i] = 2'd1;
            okTbl[i]  = 1'b1;
        end
        latTbl[2] = 10;
        xf0 = xferCount; ab0 = abortPulses;
        applyStimulus(0, 9);
        waitXfer(xf0 + 3, 300, "t5");
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("t5_busy", 32'(busy), 0);
        checkOutput("t5_done", 32'(done), 0);
        checkOutput("t5_pass", 32'(pass_cnt), 2);
        checkOutput("t5_abort_pulses", 32'(abortPulses - ab0), 1);
        repeat (12) @(negedge clk);
        checkOutput("t5_idle_done", 32'(done), 0);
        checkOutput("t5_idle_pass", 32'(pass_cnt), 2);
        applyStimulus(4, 4);
        checkOutput("t5_restart_clear", 32'(pass_cnt), 0);
        checkOutput("t5_restart_busy", 32'(busy), 1);
        waitDone(300, "t5r");
        checkOutput("t5r_pass", 32'(pass_cnt), 1);
        latTbl[2] = 3;

        // Abort while DONE has no effect
        ab0 = abortPulses;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("t5d_done", 32'(done), 1);
        checkOutput("t5d_abort_pulses", 32'(abortPulses - ab0), 0);

        // Reserved expectation counts as a failure
        expTbl[10] = 2'd3; okTbl[10] = 1'b0;
        expTbl[11] = 2'd0; okTbl[11] = 1'b0;
        applyStimulus(10, 11);
        waitDone(300, "t6");
        checkOutput("t6_pass", 32'(pass_cnt), 1);
        checkOutput("t6_fail", 32'(fail_cnt), 1);
        checkOutput("t6_ffi", 32'(first_fail_idx), 10);

        // Top of the index space
        rd0 = vecRdCount; xf0 = xferCount;
        applyStimulus(1023, 1023);
        waitDone(300, "t7");
        repeat (5) @(negedge clk);
        checkOutput("t7_vec_rd", 32'(vecRdCount - rd0), 1);
        checkOutput("t7_xfer", 32'(xferCount - xf0), 1);
        checkOutput("t7_pass", 32'(pass_cnt), 1);
        checkOutput("t7_idx", 32'(vec_idx), 1023);
        checkOutput("t7_still_done", 32'(done), 1);

        // Reset in the middle of WAIT
        latTbl[20] = 10;
        xf0 = xferCount; ab0 = abortPulses;
        applyStimulus(20, 20);
        waitXfer(xf0 + 1, 300, "t8");
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("t8_busy", 32'(busy), 0);
        checkOutput("t8_idx", 32'(vec_idx), 0);
        checkOutput("t8_pass", 32'(pass_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("t8_idle", 32'(busy | done), 0);
        checkOutput("t8_abort_pulses", 32'(abortPulses - ab0), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
